// File: rtl/axi_rd_arbiter.sv
// Two-source AXI read arbiter (fetch id0, load id1): 1-cycle AR latency, R routed combinationally by rid.
// AR payload is held until arready; requests stall while their id has OUT_MAX reads outstanding.
module axi_rd_arbiter #(
  parameter int OUT_MAX = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_arvalid,
  input  logic [31:0] inst_araddr,
  input  logic [2:0]  inst_arsize,
  output logic        inst_arready,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  input  logic        inst_rready,
  input  logic        data_arvalid,
  input  logic [31:0] data_araddr,
  input  logic [2:0]  data_arsize,
  output logic        data_arready,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  input  logic        data_rready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);

  typedef struct packed {
    logic        id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_req_t;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  localparam logic [1:0] CNT_MAX = OUT_MAX[1:0];

  state_t     r_state;
  state_t     w_state_nxt;
  ar_req_t    r_ar;
  ar_req_t    w_ar_nxt;
  logic       r_last_grant;  // 0 = fetch, 1 = load
  logic       w_last_grant_nxt;
  logic [1:0] r_cnt_inst;
  logic [1:0] r_cnt_data;
  logic       r_rd_err;

  logic w_elig_inst;
  logic w_elig_data;
  logic w_grant_inst;
  logic w_grant_data;
  logic w_ar_hs;
  logic w_inc_inst;
  logic w_inc_data;
  logic w_rid_inst;
  logic w_rid_data;
  logic w_r_hs;
  logic w_dec_inst;
  logic w_dec_data;
  logic w_unf_inst;
  logic w_unf_data;
  logic w_err_set;

  assign w_elig_inst = inst_arvalid && (r_cnt_inst < CNT_MAX);
  assign w_elig_data = data_arvalid && (r_cnt_data < CNT_MAX);

  always_comb begin
    w_state_nxt      = r_state;
    w_ar_nxt         = r_ar;
    w_last_grant_nxt = r_last_grant;
    w_grant_inst     = 1'b0;
    w_grant_data     = 1'b0;
    w_ar_hs          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_elig_inst && w_elig_data) begin
          w_grant_data = !r_last_grant;
          w_grant_inst = r_last_grant;
        end else begin
          w_grant_inst = w_elig_inst;
          w_grant_data = w_elig_data;
        end
        if (w_grant_data) begin
          w_ar_nxt         = '{id: 1'b1, addr: data_araddr, size: data_arsize};
          w_last_grant_nxt = 1'b1;
          w_state_nxt      = S_ISSUE;
        end else if (w_grant_inst) begin
          w_ar_nxt         = '{id: 1'b0, addr: inst_araddr, size: inst_arsize};
          w_last_grant_nxt = 1'b0;
          w_state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (arready) begin
          w_ar_hs     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_ar         <= '0;
      r_last_grant <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ar         <= w_ar_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Grant is gated by reset so no request is acknowledged while the block is held.
  assign inst_arready = w_grant_inst && resetn;
  assign data_arready = w_grant_data && resetn;

  assign arid    = {3'b000, r_ar.id};
  assign araddr  = r_ar.addr;
  assign arsize  = r_ar.size;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arvalid = (r_state == S_ISSUE);

  assign w_rid_inst  = (rid == 4'd0);
  assign w_rid_data  = (rid == 4'd1);
  assign rready      = w_rid_inst ? inst_rready : (w_rid_data ? data_rready : 1'b1);
  assign inst_rvalid = rvalid && w_rid_inst;
  assign data_rvalid = rvalid && w_rid_data;
  assign inst_rdata  = rdata;
  assign data_rdata  = rdata;
  assign w_r_hs      = rvalid && rready;

  assign w_inc_inst = w_ar_hs && !r_ar.id;
  assign w_inc_data = w_ar_hs && r_ar.id;
  assign w_dec_inst = w_r_hs && rlast && w_rid_inst;
  assign w_dec_data = w_r_hs && rlast && w_rid_data;
  assign w_unf_inst = w_dec_inst && !w_inc_inst && (r_cnt_inst == 2'd0);
  assign w_unf_data = w_dec_data && !w_inc_data && (r_cnt_data == 2'd0);

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic inc, input logic dec);
    logic [1:0] n;
    n = cnt;
    if (inc && !dec && (cnt < CNT_MAX)) n = cnt + 2'd1;
    else if (dec && !inc && (cnt != 2'd0)) n = cnt - 2'd1;
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt_inst <= 2'd0;
      r_cnt_data <= 2'd0;
    end else begin
      r_cnt_inst <= cnt_next(r_cnt_inst, w_inc_inst, w_dec_inst);
      r_cnt_data <= cnt_next(r_cnt_data, w_inc_data, w_dec_data);
    end
  end

  assign w_err_set = (rvalid && !w_rid_inst && !w_rid_data)
                   || (w_r_hs && (rresp != 2'b00))
                   || w_unf_inst || w_unf_data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_err <= 1'b0;
    end else if (w_err_set) begin
      r_rd_err <= 1'b1;
    end
  end

  assign rd_err = r_rd_err;

endmodule
